pipe_stall_ctrl: RTL and testbench

//   Central stall/flush sequencer for the five pipeline registers
//   (0 if_id, 1 id_ex, 2 ex_lsu1, 3 lsu1_lsu2, 4 lsu2_wb).

---
 rtl/pipe_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the five pipeline registers: turns hazard and miss
// requests into hold/bubble controls, times EX divides and keeps branch redirects pending.
module pipe_stall_ctrl #(
   parameter int DIV_LAT = 34,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             icache_stall,
   input  logic             load_use,
   input  logic             div_start,
   input  logic             dcache_stall,
   input  logic             branch_flush,
   input  logic             exception,
   output logic [4:0]       stall_o,
   output logic [4:0]       flush_o,
   output logic             exc_flush_o,
   output logic             div_busy_o,
   output logic             div_done_o,
   output logic [CNT_W-1:0] stall_cycles_o
);

   localparam int DCW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
   localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_LAT - 2);

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_DIV  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } div_state_t;

   div_state_t     div_state;
   logic [DCW-1:0] div_cnt;
   logic           pend_redir;

   logic           div_wait;
   logic           front_free;
   logic           redir;
   logic [4:0]     stall_raw;
   logic [4:0]     flush_raw;

   // Each source holds everything upstream of its blocked stage and bubbles the stage below.
   always_comb begin
      div_wait   = (div_state == S_DIV) || (div_state == S_HOLD);
      stall_raw  = '0;
      flush_raw  = '0;
      if (dcache_stall) begin
         stall_raw[3:0] = 4'b1111;
         flush_raw[4]   = 1'b1;
      end
      if (div_wait) begin
         stall_raw[1:0] = 2'b11;
         flush_raw[2]   = 1'b1;
      end
      if (load_use) begin
         stall_raw[0] = 1'b1;
         flush_raw[1] = 1'b1;
      end
      if (icache_stall) begin
         flush_raw[0] = 1'b1;
      end
      front_free = (stall_raw[1:0] == 2'b00);
      redir      = branch_flush | pend_redir;
      if (redir && front_free) begin
         flush_raw[1:0] = 2'b11;
      end
   end

   assign exc_flush_o = exception;
   assign stall_o     = exception ? 5'b00000 : stall_raw;
   assign flush_o     = exception ? 5'b00000 : (flush_raw & ~stall_raw);
   assign div_busy_o  = (div_state != S_RUN);
   assign div_done_o  = (div_state == S_DONE) && !exception;

   // A redirect that meets a held front end waits and fires on the first free cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_redir <= 1'b0;
      end else if (exception) begin
         pend_redir <= 1'b0;
      end else if (redir) begin
         pend_redir <= !front_free;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_state <= S_RUN;
         div_cnt   <= '0;
      end else if (exception) begin
         div_state <= S_RUN;
      end else begin
         case (div_state)
            S_RUN: begin
               if (div_start) begin
                  div_state <= S_DIV;
                  div_cnt   <= DIV_LOAD;
               end
            end
            S_DIV: begin
               if (div_cnt == '0) begin
                  div_state <= dcache_stall ? S_HOLD : S_DONE;
               end else begin
                  div_cnt <= div_cnt - DCW'(1);
               end
            end
            S_HOLD: begin
               if (!dcache_stall) begin
                  div_state <= S_DONE;
               end
            end
            S_DONE: begin
               div_state <= S_RUN;
            end
            default: begin
               div_state <= S_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_o <= '0;
      end else if ((|stall_o) && !(&stall_cycles_o)) begin
         stall_cycles_o <= stall_cycles_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and random stimulus for pipe_stall_ctrl, checked every cycle against a
// behavioural model built from stage boundaries and divide elapsed time.
module tb_pipe_stall_ctrl;

   localparam int DIV_LAT = 34;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic             icache_stall;
   logic             load_use;
   logic             div_start;
   logic             dcache_stall;
   logic             branch_flush;
   logic             exception;
   logic [4:0]       stall_o;
   logic [4:0]       flush_o;
   logic             exc_flush_o;
   logic             div_busy_o;
   logic             div_done_o;
   logic [CNT_W-1:0] stall_cycles_o;

   int total;
   int bad;

   bit m_busy;
   bit m_prev_dc;
   bit m_pend;
   int m_age;
   int m_cnt;

   pipe_stall_ctrl #(
      .DIV_LAT(DIV_LAT),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .icache_stall  (icache_stall),
      .load_use      (load_use),
      .div_start     (div_start),
      .dcache_stall  (dcache_stall),
      .branch_flush  (branch_flush),
      .exception     (exception),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .exc_flush_o   (exc_flush_o),
      .div_busy_o    (div_busy_o),
      .div_done_o    (div_done_o),
      .stall_cycles_o(stall_cycles_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a source blocking stage b holds registers below b and bubbles register b.
   // A divide finishes at the first elapsed cycle >= DIV_LAT whose previous cycle saw no dcache miss.
   task automatic checkOutput();
      logic [4:0] es;
      logic [4:0] ef;
      logic       edone;
      logic       ewait;
      logic       eredir;
      logic       eapply;
      int         deep;
      edone = m_busy && (m_age >= DIV_LAT) && !m_prev_dc;
      ewait = m_busy && !edone;
      deep = 0;
      if (load_use)     deep = 1;
      if (ewait)        deep = 2;
      if (dcache_stall) deep = 4;
      es = 5'((1 << deep) - 1);
      ef = '0;
      if (dcache_stall) ef[4] = 1'b1;
      if (ewait)        ef[2] = 1'b1;
      if (load_use)     ef[1] = 1'b1;
      if (icache_stall) ef[0] = 1'b1;
      eredir = branch_flush || m_pend;
      eapply = eredir && (es[1:0] == 2'b00);
      if (eapply) ef[1:0] = 2'b11;
      ef = ef & ~es;
      if (exception) begin
         es    = '0;
         ef    = '0;
         edone = 1'b0;
      end
      checkValue("stall_o",        32'(stall_o),        32'(es));
      checkValue("flush_o",        32'(flush_o),        32'(ef));
      checkValue("exc_flush_o",    32'(exc_flush_o),    32'(exception));
      checkValue("div_busy_o",     32'(div_busy_o),     32'(m_busy));
      checkValue("div_done_o",     32'(div_done_o),     32'(edone));
      checkValue("stall_cycles_o", 32'(stall_cycles_o), 32'(m_cnt));
      if (rst) begin
         m_busy = 1'b0;
         m_age  = 0;
         m_pend = 1'b0;
         m_cnt  = 0;
      end else begin
         if ((es != 5'b00000) && (m_cnt < CNT_MAX)) m_cnt++;
         if (exception) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
         end else begin
            if (eredir) m_pend = !eapply;
            if (edone) begin
               m_busy = 1'b0;
            end else if (m_busy) begin
               m_age++;
            end else if (div_start) begin
               m_busy = 1'b1;
               m_age  = 1;
            end
         end
      end
      m_prev_dc = dcache_stall;
   endtask

   task automatic applyStimulus(input bit r, input bit ic, input bit lu, input bit ds,
                                input bit dc, input bit bf, input bit ex);
      @(negedge clk);
      rst          = r;
      icache_stall = ic;
      load_use     = lu;
      div_start    = ds;
      dcache_stall = dc;
      branch_flush = bf;
      exception    = ex;
      #1;
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_busy = 1'b0; m_prev_dc = 1'b0; m_pend = 1'b0; m_age = 0; m_cnt = 0;
      rst = 1'b1; icache_stall = 1'b0; load_use = 1'b0; div_start = 1'b0;
      dcache_stall = 1'b0; branch_flush = 1'b0; exception = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] reset state");
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkValue("reset_counter", 32'(stall_cycles_o), 32'd0);

      $display("[TB] load-use bubble");
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      checkValue("lu_stall", 32'(stall_o), 32'b00001);
      checkValue("lu_flush", 32'(flush_o), 32'b00010);
      idleCycles(2);

      $display("[TB] plain divide");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0);
         if (k == DIV_LAT - 1) checkValue("div_not_done_early", 32'(div_done_o), 32'd0);
         if (k == DIV_LAT)     checkValue("div_done_at_lat",    32'(div_done_o), 32'd1);
      end
      checkValue("div_stall_count", 32'(stall_cycles_o), 32'd33);

      $display("[TB] divide held by dcache miss");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      for (int k = 1; k <= 45; k++) begin
         applyStimulus(0, 0, 0, 0, (k >= 20 && k <= 40), 0, 0);
         if (k == 36) checkValue("hold_stall", 32'(stall_o), 32'b01111);
         if (k == 36) checkValue("hold_flush", 32'(flush_o), 32'b10000);
         if (k == 42) checkValue("hold_done",  32'(div_done_o), 32'd1);
      end
      checkValue("hold_stall_count", 32'(stall_cycles_o), 32'd41);

      $display("[TB] branch redirect across dcache miss");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0);
      checkValue("redir_blocked", 32'(flush_o[1:0]), 32'd0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkValue("redir_applied", 32'(flush_o), 32'b00011);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkValue("redir_once", 32'(flush_o), 32'd0);

      $display("[TB] exception aborts divide and pending redirect");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      idleCycles(4);
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkValue("exc_flush", 32'(exc_flush_o), 32'd1);
      checkValue("exc_stall", 32'(stall_o),     32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkValue("exc_busy_cleared", 32'(div_busy_o), 32'd0);
      idleCycles(40);

      $display("[TB] counter saturation and mid-divide reset");
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 260; k++) applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkValue("counter_saturated", 32'(stall_cycles_o), 32'(CNT_MAX));
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      idleCycles(10);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkValue("rst_stall",   32'(stall_o),        32'd0);
      checkValue("rst_busy",    32'(div_busy_o),     32'd0);
      checkValue("rst_counter", 32'(stall_cycles_o), 32'd0);

      $display("[TB] random traffic");
      for (int k = 0; k < 2000; k++) begin
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 99) < 25,
                       $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 15,
                       $urandom_range(0, 99) < 10,
                       $urandom_range(0, 99) < 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
